// File: rtl/fdd_timing_pkg.sv
// Shared timing constants, rotation state encoding and width helpers for the floppy drive model.
// All durations are counted in 1 MHz tick_us units.
package fdd_timing_pkg;

  localparam int unsigned DEF_ROT_PERIOD_US  = 200000;
  localparam int unsigned DEF_INDEX_WIDTH_US = 4000;
  localparam int unsigned DEF_SPINUP_US      = 500000;
  localparam int unsigned DEF_SPINDOWN_US    = 1000000;

  typedef enum logic [1:0] {
    ROT_OFF      = 2'd0,
    ROT_SPINUP   = 2'd1,
    ROT_READY    = 2'd2,
    ROT_SPINDOWN = 2'd3
  } fdd_rot_state_t;

  function automatic int unsigned fdd_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned DEF_ROT_POS_W = $clog2(DEF_ROT_PERIOD_US);
  localparam int unsigned DEF_TIMER_W   = $clog2(fdd_max(DEF_SPINUP_US, DEF_SPINDOWN_US) + 1);

endpackage

// File: rtl/fdd_rot_pos_counter.sv
// Tick-enabled modulo-PERIOD position counter with a wrap flag; pos_o is registered, 1 clk after en_i.
// No backpressure: every enabled cycle advances; clr_i wins over en_i and suppresses the wrap flag.
module fdd_rot_pos_counter #(
  parameter int unsigned PERIOD = 20,
  parameter int unsigned W      = $clog2(PERIOD)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] pos_o,
  output logic [W-1:0] pos_next_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] pos_q, pos_d;

  always_comb begin
    pos_d  = pos_q;
    wrap_o = 1'b0;
    if (clr_i) begin
      pos_d = '0;
    end else if (en_i) begin
      if (pos_q == LAST) begin
        pos_d  = '0;
        wrap_o = 1'b1;
      end else begin
        pos_d = pos_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pos_q <= '0;
    else          pos_q <= pos_d;
  end

  assign pos_o      = pos_q;
  assign pos_next_o = pos_d;

endmodule

// File: rtl/fdd_rotation_timer.sv
// Floppy drive mechanics: spin-up/down FSM, rotation position, index, ready and rev_strobe; outputs registered, 1 clk.
// No backpressure; `define FDD_FAST_SPINUP_EN shortens SPINUP to a single tick.
module fdd_rotation_timer
  import fdd_timing_pkg::*;
#(
  parameter int unsigned ROT_PERIOD_US  = DEF_ROT_PERIOD_US,
  parameter int unsigned INDEX_WIDTH_US = DEF_INDEX_WIDTH_US,
  parameter int unsigned SPINUP_US      = DEF_SPINUP_US,
  parameter int unsigned SPINDOWN_US    = DEF_SPINDOWN_US,
  localparam int unsigned POS_W   = $clog2(ROT_PERIOD_US),
  localparam int unsigned TIMER_W = $clog2(fdd_max(SPINUP_US, SPINDOWN_US) + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_us,
  input  logic             motor_on,
  input  logic             disk_present,
  output logic             spinning,
  output logic             ready,
  output logic             index,
  output logic             rev_strobe,
  output logic [POS_W-1:0] rot_pos
);

`ifdef FDD_FAST_SPINUP_EN
  localparam logic [TIMER_W-1:0] SPINUP_LOAD = '0;
`else
  localparam logic [TIMER_W-1:0] SPINUP_LOAD = TIMER_W'(SPINUP_US - 1);
`endif
  localparam logic [TIMER_W-1:0] SPINDOWN_LOAD = TIMER_W'(SPINDOWN_US - 1);

  fdd_rot_state_t     state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pos_en, pos_clr, pos_wrap;
  logic [POS_W-1:0]   pos_next;
  logic               spinning_q, ready_q, index_q, rev_strobe_q;
  logic               spin_d;

  // motor_on edges take priority over the tick: reload, never decrement, on those cycles.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pos_clr = 1'b0;
    case (state_q)
      ROT_OFF: begin
        if (motor_on) begin
          state_d = ROT_SPINUP;
          timer_d = SPINUP_LOAD;
        end
      end
      ROT_SPINUP: begin
        if (!motor_on) begin
          state_d = ROT_SPINDOWN;
          timer_d = SPINDOWN_LOAD;
        end else if (tick_us) begin
          if (timer_q == '0) state_d = ROT_READY;
          else               timer_d = timer_q - TIMER_W'(1);
        end
      end
      ROT_READY: begin
        if (!motor_on) begin
          state_d = ROT_SPINDOWN;
          timer_d = SPINDOWN_LOAD;
        end
      end
      ROT_SPINDOWN: begin
        if (motor_on) begin
          state_d = ROT_READY;
        end else if (tick_us) begin
          if (timer_q == '0) begin
            state_d = ROT_OFF;
            pos_clr = 1'b1;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end
      default: state_d = ROT_OFF;
    endcase
  end

  assign pos_en = tick_us && (state_q != ROT_OFF);
  assign spin_d = (state_d != ROT_OFF);

  fdd_rot_pos_counter #(
    .PERIOD (ROT_PERIOD_US),
    .W      (POS_W)
  ) u_rot_pos (
    .clk_i      (clk),
    .rst_n_i    (reset_n),
    .en_i       (pos_en),
    .clr_i      (pos_clr),
    .pos_o      (rot_pos),
    .pos_next_o (pos_next),
    .wrap_o     (pos_wrap)
  );

  // Flags are built from next-state values so they line up with the state and rot_pos registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ROT_OFF;
      timer_q      <= '0;
      spinning_q   <= 1'b0;
      ready_q      <= 1'b0;
      index_q      <= 1'b0;
      rev_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      spinning_q   <= spin_d;
      ready_q      <= (state_d == ROT_READY) && disk_present;
      index_q      <= spin_d && disk_present && (pos_next < POS_W'(INDEX_WIDTH_US));
      rev_strobe_q <= pos_wrap && disk_present;
    end
  end

  assign spinning   = spinning_q;
  assign ready      = ready_q;
  assign index      = index_q;
  assign rev_strobe = rev_strobe_q;

endmodule

// File: tb/tb_fdd_rotation_timer.sv
// Directed bench for fdd_rotation_timer with a short 20-tick revolution and a tick every 4 clk.
module tb_fdd_rotation_timer;

  localparam int ROT = 20;
  localparam int IW  = 3;
  localparam int SU  = 50;
  localparam int SD  = 30;
`ifdef FDD_FAST_SPINUP_EN
  localparam int SPIN_TICKS   = 1;
  localparam int GLITCH_TICKS = 0;
`else
  localparam int SPIN_TICKS   = SU;
  localparam int GLITCH_TICKS = 5;
`endif

  logic       clk = 1'b0;
  logic       reset_n, tick_us, motor_on, disk_present;
  logic       spinning, ready, index, rev_strobe;
  logic [4:0] rot_pos;

  int errors = 0;
  int checks = 0;
  int exp_pos = 0;

  always #5 clk = ~clk;

  fdd_rotation_timer #(
    .ROT_PERIOD_US  (ROT),
    .INDEX_WIDTH_US (IW),
    .SPINUP_US      (SU),
    .SPINDOWN_US    (SD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick_us      (tick_us),
    .motor_on     (motor_on),
    .disk_present (disk_present),
    .spinning     (spinning),
    .ready        (ready),
    .index        (index),
    .rev_strobe   (rev_strobe),
    .rot_pos      (rot_pos)
  );

  // {spinning, ready, index, rev_strobe, rot_pos}
  function automatic logic [8:0] outs();
    return {spinning, ready, index, rev_strobe, rot_pos};
  endfunction

  function automatic logic [8:0] expv(input bit s, input bit r, input bit st, input int p, input bit dp);
    logic [4:0] p5;
    p5 = 5'(p);
    return {s, r & dp, s & dp & (p < IW), st & dp, p5};
  endfunction

  task automatic cyc(input logic t);
    tick_us = t;
    @(posedge clk);
    #1;
  endtask

  task automatic tick4();
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; motor_on = 1'b0; disk_present = 1'b1; tick_us = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs() !== 9'h0) begin
      errors++; $display("FAIL reset: got %h want %h", outs(), 9'h0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick4();
      checks++;
      if (outs() !== 9'h0) begin
        errors++; $display("FAIL off_idle tick %0d: got %h want %h", i, outs(), 9'h0);
      end
    end
  endtask

  task automatic test_spinup();
    logic [8:0] e;
    motor_on = 1'b1;
    cyc(1'b0);
    exp_pos = 0;
    e = expv(1, 0, 0, exp_pos, 1);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL spinup_entry: got %h want %h", outs(), e);
    end
    for (int k = 1; k <= SPIN_TICKS; k++) begin
      tick4();
      exp_pos = (exp_pos + 1) % ROT;
      e = expv(1, k == SPIN_TICKS, exp_pos == 0, exp_pos, 1);
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL spinup_tick %0d: got %h want %h", k, outs(), e);
      end
    end
  endtask

  task automatic test_revolution();
    logic [8:0] e;
    int strobes = 0;
    int idx = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0);
      checks++;
      if (rev_strobe !== 1'b0) begin
        errors++; $display("FAIL strobe_width %0d: got %b want 0", k, rev_strobe);
      end
      cyc(1'b0); cyc(1'b0); cyc(1'b1);
      exp_pos = (exp_pos + 1) % ROT;
      e = expv(1, 1, exp_pos == 0, exp_pos, 1);
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL ready_rev %0d: got %h want %h", k, outs(), e);
      end
      if (rev_strobe === 1'b1) strobes++;
      if (index === 1'b1) idx++;
    end
    checks++;
    if (strobes !== 2) begin
      errors++; $display("FAIL strobe_count: got %0d want 2", strobes);
    end
    checks++;
    if (idx !== 2 * IW) begin
      errors++; $display("FAIL index_ticks: got %0d want %0d", idx, 2 * IW);
    end
  endtask

  task automatic test_spindown_restart();
    logic [8:0] e;
    motor_on = 1'b0;
    cyc(1'b0);
    e = expv(1, 0, 0, exp_pos, 1);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL spindown_entry: got %h want %h", outs(), e);
    end
    for (int k = 1; k <= 10; k++) begin
      tick4();
      exp_pos = (exp_pos + 1) % ROT;
      e = expv(1, 0, exp_pos == 0, exp_pos, 1);
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL spindown_run %0d: got %h want %h", k, outs(), e);
      end
    end
    motor_on = 1'b1;
    cyc(1'b0);
    e = expv(1, 1, 0, exp_pos, 1);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL restart_ready: got %h want %h", outs(), e);
    end
    // Drop motor_on on a tick cycle: reload wins, rot_pos still advances.
    motor_on = 1'b0;
    cyc(1'b1);
    exp_pos = (exp_pos + 1) % ROT;
    e = expv(1, 0, exp_pos == 0, exp_pos, 1);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL spindown_on_tick: got %h want %h", outs(), e);
    end
    for (int k = 1; k <= SD; k++) begin
      tick4();
      if (k < SD) begin
        exp_pos = (exp_pos + 1) % ROT;
        e = expv(1, 0, exp_pos == 0, exp_pos, 1);
      end else begin
        exp_pos = 0;
        e = 9'h0;
      end
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL spindown_full %0d: got %h want %h", k, outs(), e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick4();
      checks++;
      if (outs() !== 9'h0) begin
        errors++; $display("FAIL off_hold %0d: got %h want %h", k, outs(), 9'h0);
      end
    end
  endtask

  task automatic test_motor_glitch();
    logic [8:0] e;
    motor_on = 1'b1;
    cyc(1'b0);
    exp_pos = 0;
    e = expv(1, 0, 0, 0, 1);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL glitch_entry: got %h want %h", outs(), e);
    end
    for (int k = 0; k < GLITCH_TICKS; k++) begin
      tick4();
      exp_pos = (exp_pos + 1) % ROT;
    end
    motor_on = 1'b0;
    cyc(1'b1);
    exp_pos = (exp_pos + 1) % ROT;
    e = expv(1, 0, 0, exp_pos, 1);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL glitch_to_spindown: got %h want %h", outs(), e);
    end
    motor_on = 1'b1;
    cyc(1'b1);
    exp_pos = (exp_pos + 1) % ROT;
    e = expv(1, 1, 0, exp_pos, 1);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL glitch_to_ready: got %h want %h", outs(), e);
    end
  endtask

  task automatic test_disk_present();
    logic [8:0] e;
    disk_present = 1'b0;
    cyc(1'b0);
    e = expv(1, 1, 0, exp_pos, 0);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL disk_gone: got %h want %h", outs(), e);
    end
    for (int k = 0; k < ROT; k++) begin
      tick4();
      exp_pos = (exp_pos + 1) % ROT;
      e = expv(1, 1, exp_pos == 0, exp_pos, 0);
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL disk_gone_run %0d: got %h want %h", k, outs(), e);
      end
    end
    disk_present = 1'b1;
    cyc(1'b0);
    e = expv(1, 1, 0, exp_pos, 1);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL disk_back: got %h want %h", outs(), e);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    cyc(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 9'h0) begin
      errors++; $display("FAIL async_reset: got %h want %h", outs(), 9'h0);
    end
    motor_on = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_pos = 0;
    for (int k = 0; k < 5; k++) begin
      tick4();
      checks++;
      if (outs() !== 9'h0) begin
        errors++; $display("FAIL reset_no_spindown %0d: got %h want %h", k, outs(), 9'h0);
      end
    end
    motor_on = 1'b1;
    cyc(1'b1);
    e = expv(1, 0, 0, 0, 1);
    checks++;
    if (outs() !== e) begin
      errors++; $display("FAIL restart_after_reset: got %h want %h", outs(), e);
    end
  endtask

  initial begin
    test_reset();
    test_spinup();
    test_revolution();
    test_spindown_restart();
    test_motor_glitch();
    test_disk_present();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fdd_rotation_timer.md
Name: fdd_rotation_timer

Overview:
- Consumes the 1 MHz clock-enable tick (tick_us) from the FDD clock-enable divider.
- Models the mechanical timing of one floppy drive: motor spin-up, spin-down, the rotation position within a revolution, the index pulse and drive-ready.
- Feeds the FDC core, which uses index, ready and rev_strobe for index counting, timeouts and sector timing.

Parameters:
ROT_PERIOD_US, 200000, revolution period in tick_us units (300 rpm).
INDEX_WIDTH_US, 4000, index pulse width in ticks; 1 <= INDEX_WIDTH_US < ROT_PERIOD_US.
SPINUP_US, 500000, ticks from motor-on until ready; must be >= 1.
SPINDOWN_US, 1000000, ticks the disc keeps spinning after motor-off; must be >= 1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
tick_us  in  1  one-clk enable pulse at 1 MHz from the clock-enable divider
motor_on  in  1  motor request from the FDC/drive-select latch (level)
disk_present  in  1  disc inserted (level)
spinning  out  1  disc rotating (state SPINUP, READY or SPINDOWN)
ready  out  1  drive ready
index  out  1  index pulse, active high
rev_strobe  out  1  one-clk pulse per revolution start
rot_pos  out  $clog2(ROT_PERIOD_US)  position within the revolution, in ticks

Behaviour:
- Reset (async assert, sync release): state OFF, timer 0, rot_pos 0; spinning, ready, index and rev_strobe all 0.
- All outputs are registered. Each output reflects the state and counters one clk after the causing edge.
- States are OFF, SPINUP, READY and SPINDOWN.
- OFF:
  - motor_on=1 -> SPINUP, timer <= SPINUP_US-1.
  - rot_pos is held at 0.
- SPINUP:
  - On each tick: if timer==0 -> READY, else timer decrements.
  - motor_on=0 -> SPINDOWN, timer <= SPINDOWN_US-1.
  - ready asserts exactly SPINUP_US ticks after entry.
- READY:
  - motor_on=0 -> SPINDOWN, timer <= SPINDOWN_US-1.
- SPINDOWN:
  - motor_on=1 -> READY immediately, with no new spin-up.
  - On each tick: if timer==0 -> OFF and rot_pos <= 0; else timer decrements.
- Timer width is $clog2(max(SPINUP_US,SPINDOWN_US)+1).
- Priority: a motor_on-driven transition beats the tick. On that cycle the timer is reloaded, not decremented.
- rot_pos:
  - Increments on tick while spinning.
  - Wraps from ROT_PERIOD_US-1 to 0.
  - A tick coinciding with a state change still advances rot_pos, except on the SPINDOWN->OFF transition, where rot_pos is cleared.
- index = spinning & disk_present & (rot_pos < INDEX_WIDTH_US).
- rev_strobe: 1 clk, on the cycle after the tick that wraps rot_pos to 0, qualified by disk_present. It does not fire on SPINUP entry.
- ready = (state==READY) & disk_present.
- disk_present=0: index, ready and rev_strobe are forced 0 from the next clk. The state machine and rot_pos continue unaffected.
- tick_us is ignored in OFF, except that an OFF->SPINUP transition on a tick cycle takes the reload only.
- Reset mid-operation returns to OFF with no spin-down phase.

Optional Feature:
FDD_FAST_SPINUP_EN
- Defined: SPINUP lasts one tick (timer loads 0), so ready asserts on the first tick after motor_on. Intended for simulation and fast-boot builds.
- Undefined: full SPINUP_US behaviour as above.
- SPINDOWN is identical in both cases.

Decomposition:
- Package fdd_timing_pkg:
  - state enum fdd_rot_state_t (OFF, SPINUP, READY, SPINDOWN).
  - Default constants ROT_PERIOD_US, INDEX_WIDTH_US, SPINUP_US, SPINDOWN_US.
  - Width helper constants.
- Sub-module fdd_rot_pos_counter: the tick-enabled wrap counter, producing rot_pos and the wrap flag. It is reused by the data-byte timing stage.

Test Plan (ROT_PERIOD_US=20, INDEX_WIDTH_US=3, SPINUP_US=50, SPINDOWN_US=30, tick every 4 clk, disk_present=1):
- Reset release, motor_on=0 for 100 ticks -> spinning=0, ready=0, index=0, rot_pos=0 throughout.
- Spin-up timing: motor_on=1 -> spinning=1 on the next clk; ready=1 one clk after the 50th tick; index high for rot_pos 0..2.
- Revolution timing: in READY -> rev_strobe once every 20 ticks (80 clk), one clk wide; index high for 3 ticks per revolution.
- Spin-down and early restart:
  - motor_on=0 in READY -> ready=0 the next clk; index keeps running.
  - OFF after the 30th tick, with rot_pos=0.
  - Reassert motor_on at tick 10 -> ready=1 the next clk.
- disk_present and motor_on glitch:
  - disk_present=0 in READY -> index, ready and rev_strobe are 0 next clk while rot_pos keeps counting; restoring disk_present brings ready back the next clk.
  - motor_on toggled 1->0->1 within SPINUP -> SPINDOWN then READY, with no timer decrement on the transition cycles.
- Macro and reset variants:
  - With FDD_FAST_SPINUP_EN: ready=1 after the first tick following motor_on.
  - reset_n pulsed low mid-READY -> all outputs 0 asynchronously.
